mem_arbiter: RTL and testbench

- Shares the single 16-bit memory port between two requesters: the instruction fetcher (read only) and the execute unit (loads/stores).
- Both sides use the codebase's req/done handshake: the requester holds request high, with address and data stable, until it sees a one-cycle done pulse.
- The arbiter registers the selected request onto the memory side and returns done/data to the winner.
- A watchdog aborts transactions that memory never completes.

---
 rtl/proc1_mem_pkg.sv | 17 +
 rtl/mem_arbiter_watchdog.sv | 35 +++
 rtl/mem_arbiter.sv | 159 +++++++++++++++
 tb/tb_mem_arbiter.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/proc1_mem_pkg.sv
// Shared encodings for the memory-port arbiter: one-hot states, requester IDs
// and the read pattern returned on a watchdog abort.
package proc1_mem_pkg;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'b0001,
    ST_BUSY_F  = 4'b0010,
    ST_BUSY_E  = 4'b0100,
    ST_RELEASE = 4'b1000
  } arb_state_e;

  localparam logic REQ_FETCH = 1'b0;
  localparam logic REQ_EXEC  = 1'b1;

  localparam logic [15:0] TIMEOUT_RDATA = 16'hFFFF;

endpackage

// File: rtl/mem_arbiter_watchdog.sv
// Cycle counter for an outstanding memory transaction; expire_o flags the
// last permitted cycle (count == TIMEOUT-1) while counting is enabled.
module mem_arbiter_watchdog #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = en_i && (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single memory port between fetcher and execute unit with a
// watchdog abort. Define MEM_ARBITER_ROUND_ROBIN_EN for round-robin priority.
module mem_arbiter
  import proc1_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetchRequest,
  input  logic [15:0] fetchAddress,
  output logic        fetchDone,
  output logic [15:0] fetchReadData,
  input  logic        execRequest,
  input  logic        execWrite,
  input  logic [15:0] execAddress,
  input  logic [15:0] execWriteData,
  output logic        execDone,
  output logic [15:0] execReadData,
  output logic        memoryRequest,
  output logic        memoryWrite,
  output logic [15:0] memoryAddress,
  output logic [15:0] memoryWriteData,
  input  logic        memoryDone,
  input  logic [15:0] memoryReadData,
  output logic        timeoutError
);

  arb_state_e  state_q, state_d;
  logic        mreq_q, mreq_d, mwe_q, mwe_d;
  logic [15:0] maddr_q, maddr_d, mwd_q, mwd_d;
  logic        fdone_q, fdone_d, edone_q, edone_d, tmo_q, tmo_d;
  logic [15:0] frd_q, frd_d, erd_q, erd_d;
  logic        busy, expire, finish, exec_wins;
  logic [15:0] done_data;

  assign busy      = (state_q == ST_BUSY_F) || (state_q == ST_BUSY_E);
  assign finish    = busy && (memoryDone || expire);
  // A real completion always beats a coincident watchdog expiry.
  assign done_data = memoryDone ? memoryReadData : TIMEOUT_RDATA;

  mem_arbiter_watchdog #(
    .TIMEOUT(TIMEOUT),
    .CNT_W  (CNT_W)
  ) u_watchdog (
    .clk     (clk),
    .rst     (reset),
    .clr_i   (finish),
    .en_i    (busy),
    .expire_o(expire)
  );

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  logic ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (finish) begin
      ptr_d = (state_q == ST_BUSY_E) ? REQ_FETCH : REQ_EXEC;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= REQ_EXEC;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign exec_wins = execRequest && (!fetchRequest || (ptr_q == REQ_EXEC));
`else
  assign exec_wins = execRequest;
`endif

  always_comb begin
    state_d = state_q;
    mreq_d  = mreq_q;
    mwe_d   = mwe_q;
    maddr_d = maddr_q;
    mwd_d   = mwd_q;
    frd_d   = frd_q;
    erd_d   = erd_q;
    fdone_d = 1'b0;
    edone_d = 1'b0;
    tmo_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (exec_wins) begin
          state_d = ST_BUSY_E;
          mreq_d  = 1'b1;
          mwe_d   = execWrite;
          maddr_d = execAddress;
          mwd_d   = execWriteData;
        end else if (fetchRequest) begin
          state_d = ST_BUSY_F;
          mreq_d  = 1'b1;
          mwe_d   = 1'b0;
          maddr_d = fetchAddress;
        end
      end
      ST_BUSY_F, ST_BUSY_E: begin
        if (finish) begin
          state_d = ST_RELEASE;
          mreq_d  = 1'b0;
          mwe_d   = 1'b0;
          tmo_d   = !memoryDone;
          if (state_q == ST_BUSY_F) begin
            fdone_d = 1'b1;
            frd_d   = done_data;
          end else begin
            edone_d = 1'b1;
            erd_d   = done_data;
          end
        end
      end
      ST_RELEASE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      mreq_q  <= 1'b0;
      mwe_q   <= 1'b0;
      maddr_q <= '0;
      mwd_q   <= '0;
      fdone_q <= 1'b0;
      edone_q <= 1'b0;
      tmo_q   <= 1'b0;
      frd_q   <= '0;
      erd_q   <= '0;
    end else begin
      state_q <= state_d;
      mreq_q  <= mreq_d;
      mwe_q   <= mwe_d;
      maddr_q <= maddr_d;
      mwd_q   <= mwd_d;
      fdone_q <= fdone_d;
      edone_q <= edone_d;
      tmo_q   <= tmo_d;
      frd_q   <= frd_d;
      erd_q   <= erd_d;
    end
  end

  assign memoryRequest   = mreq_q;
  assign memoryWrite     = mwe_q;
  assign memoryAddress   = maddr_q;
  assign memoryWriteData = mwd_q;
  assign fetchDone       = fdone_q;
  assign fetchReadData   = frd_q;
  assign execDone        = edone_q;
  assign execReadData    = erd_q;
  assign timeoutError    = tmo_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: random requesters and a random-latency
// memory, checked every cycle against a transaction-level reference model.
module tb_mem_arbiter;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fetchRequest = 1'b0;
  logic [15:0] fetchAddress = '0;
  logic        fetchDone;
  logic [15:0] fetchReadData;
  logic        execRequest = 1'b0;
  logic        execWrite = 1'b0;
  logic [15:0] execAddress = '0;
  logic [15:0] execWriteData = '0;
  logic        execDone;
  logic [15:0] execReadData;
  logic        memoryRequest;
  logic        memoryWrite;
  logic [15:0] memoryAddress;
  logic [15:0] memoryWriteData;
  logic        memoryDone = 1'b0;
  logic [15:0] memoryReadData = '0;
  logic        timeoutError;

  mem_arbiter #(.TIMEOUT(TO), .CNT_W(3)) dut (
    .clk(clk), .reset(reset),
    .fetchRequest(fetchRequest), .fetchAddress(fetchAddress),
    .fetchDone(fetchDone), .fetchReadData(fetchReadData),
    .execRequest(execRequest), .execWrite(execWrite),
    .execAddress(execAddress), .execWriteData(execWriteData),
    .execDone(execDone), .execReadData(execReadData),
    .memoryRequest(memoryRequest), .memoryWrite(memoryWrite),
    .memoryAddress(memoryAddress), .memoryWriteData(memoryWriteData),
    .memoryDone(memoryDone), .memoryReadData(memoryReadData),
    .timeoutError(timeoutError)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int txns = 0;

  // Reference model: owner 0=none 1=fetch 2=exec; cool=1 for the release gap.
  int          owner, busy_cnt, cool;
  logic        ptr_exec;
  logic        exp_mreq, exp_mwe, exp_fd, exp_ed, exp_tmo;
  logic [15:0] exp_maddr, exp_mwd, exp_frd, exp_erd;

  logic hold_mem = 1'b0;
  logic mem_active = 1'b0;
  int   mem_cyc, mem_k;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %h, expected %h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    owner = 0; busy_cnt = 0; cool = 0; ptr_exec = 1'b1;
    exp_mreq = 0; exp_mwe = 0; exp_fd = 0; exp_ed = 0; exp_tmo = 0;
    exp_maddr = '0; exp_mwd = '0; exp_frd = '0; exp_erd = '0;
  endtask

  function automatic logic exec_first();
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    return ptr_exec;
`else
    return 1'b1;
`endif
  endfunction

  task automatic finish_txn(input logic [15:0] d, input logic t);
    exp_mreq = 0; exp_mwe = 0; exp_tmo = t;
    if (owner == 1) begin exp_fd = 1; exp_frd = d; end
    else begin exp_ed = 1; exp_erd = d; end
    ptr_exec = (owner == 1);
    owner = 0; cool = 1;
  endtask

  // Advances the model over the clock edge just taken, using the inputs that
  // were present at that edge (still held at the following negedge).
  task automatic model_step();
    exp_fd = 0; exp_ed = 0; exp_tmo = 0;
    if (owner != 0) begin
      busy_cnt++;
      if (memoryDone) finish_txn(memoryReadData, 1'b0);
      else if (busy_cnt == TO) finish_txn(16'hFFFF, 1'b1);
    end else if (cool != 0) begin
      cool = 0;
    end else if (execRequest && (!fetchRequest || exec_first())) begin
      owner = 2; busy_cnt = 0; exp_mreq = 1; exp_mwe = execWrite;
      exp_maddr = execAddress; exp_mwd = execWriteData;
    end else if (fetchRequest) begin
      owner = 1; busy_cnt = 0; exp_mreq = 1; exp_mwe = 0;
      exp_maddr = fetchAddress;
    end
  endtask

  task automatic check_outputs();
    chk("memoryRequest", memoryRequest, exp_mreq);
    chk("memoryWrite", memoryWrite, exp_mwe);
    chk("memoryAddress", memoryAddress, exp_maddr);
    if (owner == 2 && exp_mwe) chk("memoryWriteData", memoryWriteData, exp_mwd);
    chk("fetchDone", fetchDone, exp_fd);
    chk("execDone", execDone, exp_ed);
    chk("fetchReadData", fetchReadData, exp_frd);
    chk("execReadData", execReadData, exp_erd);
    chk("timeoutError", timeoutError, exp_tmo);
  endtask

  task automatic step(input bit rand_en);
    @(negedge clk);
    model_step();
    check_outputs();
    if (exp_fd || exp_ed) begin
      txns++;
      $display("txn %0d: %s data=%h timeout=%0b t=%0t", txns, exp_fd ? "fetch" : "exec ",
               exp_fd ? exp_frd : exp_erd, exp_tmo, $time);
    end
    if (fetchDone) fetchRequest = 0;
    else if (rand_en && !fetchRequest && $urandom_range(0, 2) == 0) begin
      fetchRequest = 1; fetchAddress = 16'($urandom);
    end
    if (execDone) execRequest = 0;
    else if (rand_en && !execRequest && $urandom_range(0, 2) == 0) begin
      execRequest = 1; execWrite = 1'($urandom_range(0, 1));
      execAddress = 16'($urandom); execWriteData = 16'($urandom);
    end
    memoryDone = 0;
    if (memoryRequest && !hold_mem) begin
      if (!mem_active) begin
        mem_active = 1; mem_cyc = 0; mem_k = $urandom_range(1, TO + 2);
      end
      mem_cyc++;
      if (mem_cyc == mem_k) begin
        memoryDone = 1; memoryReadData = 16'($urandom);
      end
    end else begin
      mem_active = 0;
    end
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs();
    reset = 0;

    fetchRequest = 1; fetchAddress = 16'h0010;
    repeat (12) step(0);

    execRequest = 1; execWrite = 1; execAddress = 16'h0200; execWriteData = 16'h1234;
    fetchRequest = 1; fetchAddress = 16'h0020;
    repeat (24) step(0);

    repeat (3000) step(1);
    repeat (30) step(0);

    // Asynchronous reset in the middle of an exec transaction.
    hold_mem = 1;
    execRequest = 1; execWrite = 0; execAddress = 16'h0300;
    for (int i = 0; i < 10 && !memoryRequest; i++) step(0);
    chk("busy_e_before_reset", memoryRequest, 1);
    #2 reset = 1;
    #1;
    chk("async_rst_memoryRequest", memoryRequest, 0);
    chk("async_rst_memoryAddress", memoryAddress, 0);
    chk("async_rst_execDone", execDone, 0);
    chk("async_rst_fetchReadData", fetchReadData, 0);
    chk("async_rst_execReadData", execReadData, 0);
    execRequest = 0; fetchRequest = 0; memoryDone = 0;
    @(negedge clk);
    chk("rst_no_execDone", execDone, 0);
    model_reset();
    mem_active = 0; hold_mem = 0;
    reset = 0;

    fetchRequest = 1; fetchAddress = 16'h0040;
    execRequest = 1; execWrite = 0; execAddress = 16'h0300;
    step(0);
    chk("post_reset_exec_priority", memoryAddress, 16'h0300);
    repeat (400) step(1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
